jx2_ex_alu_resolve: RTL
=======================

JX2_EX_ALU_RESOLVE -- requirements
Module: jx2_ex_alu_resolve

Interface
REQ-001 SHALL have port clock, input, 1 bit: single rising-edge clock.
REQ-002 SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-003 SHALL have inputs validIn (1), holdIn (1), flushIn (1), opIn (4), tIn (1, current SR.T), regIdRnIn (7, destination register).
REQ-004 SHALL have inputs rmSign (1) and riSign (1): bit 63 of Rm and bit 63 of Ri.
REQ-005 SHALL have 33-bit inputs addRmRi_A0, addRmRi_A1, addRmRi_B0, addRmRi_B1, subRmRi_A0, subRmRi_A1, subRmRi_B0, subRmRi_B1: carry-select half-sums from the adder stage.
REQ-006 SHALL have 64-bit inputs aluPAddW, aluPAddL, aluPSubW, aluPSubL: packed results.
REQ-007 SHALL have outputs validOut (1), regIdRnOut (7), regValRnOut (64), tOut (1), tWrOut (1), xHiOut (1, ADDX/SUBX high-half phase pending).

Function
REQ-008 SHALL register all outputs; latency from an accepted input to its output is exactly 1 cycle.
REQ-009 Input SHALL be accepted when validIn=1, holdIn=0 and flushIn=0.
REQ-010 holdIn=1 SHALL freeze all outputs and the FSM; holdIn takes priority over validIn.
REQ-011 flushIn=1 with holdIn=0 SHALL clear validOut and tWrOut at the next edge and force the FSM to IDLE.
REQ-012 When nothing is accepted and holdIn=0, validOut and tWrOut SHALL be 0; other outputs hold their values.
REQ-013 Add chain with carry-in c: L = c ? addRmRi_A1 : addRmRi_A0; H = L[32] ? addRmRi_B1 : addRmRi_B0; result = {H[31:0], L[31:0]}; carry-out = H[32].
REQ-014 Subtract chain SHALL be identical using the subRmRi_* inputs; carry-out 1 means no borrow.
REQ-015 opIn decode:
  - 0 NOP: validOut=0.
  - 1 ADD: c=0.
  - 2 SUB: c=1.
  - 3 ADC: c=tIn; tOut=carry-out.
  - 4 SBB: c=~tIn; tOut=~carry-out.
  - 5 CMPEQ: sub c=1; tOut=(result==0).
  - 6 CMPGT, signed: sub c=1; V=(rmSign^riSign)&(rmSign^result[63]); tOut=(result!=0)&(result[63]==V).
  - 7 CMPHI, unsigned: sub c=1; tOut=carry-out&(result!=0).
  - 8 ADDL, 9 SUBL: low 32 bits of the ADD/SUB result, sign-extended to 64 bits.
  - A PADDW, B PADDL, C PSUBW, D PSUBL: pass the matching packed input through.
  - E ADDX, F SUBX: 128-bit operation, see REQ-017.
REQ-016 tWrOut SHALL be 1 only for ops 3-7 and for ADDX/SUBX high halves. CMP ops 5-7 SHALL produce validOut=0 (no GPR write).
REQ-017 FSM states IDLE and HI:
  - IDLE: accepted E/F uses c=0 (E) or c=1 (F), writes the low result, stores carry-out in xCarry, then moves to HI; xHiOut=1 in HI.
  - HI: the next accepted op SHALL be treated as the high half of the same opcode class, using c=xCarry. It writes its result, sets tOut to carry-out (E) or ~carry-out (F) with tWrOut=1, then returns to IDLE.
  - HI: an accepted op other than E/F SHALL abort to IDLE and execute normally.
REQ-018 All arithmetic SHALL be modulo 2^64 with no saturation.

Reset
REQ-019 While reset=0: validOut=0, tWrOut=0, tOut=0, xHiOut=0, regIdRnOut=0, regValRnOut=0, xCarry=0, FSM=IDLE.
REQ-020 Reset assertion mid-ADDX SHALL discard the pending high phase; the first accepted op after release decodes from IDLE.

Configuration
REQ-021 Macro JX2_ALU_ADDX_EN:
  - Defined: ops E/F and the HI state SHALL exist as specified.
  - Undefined: ops E/F SHALL behave as NOP, the FSM and xCarry SHALL be omitted, and xHiOut SHALL be tied to 0.

Verification
REQ-022 ADD: A0=0x1_0000_0000 (carry set), B1=0x0_0000_0005, opIn=1 -> next cycle regValRnOut=0x0000_0005_0000_0000, validOut=1, tWrOut=0.
REQ-023 SBB with tIn=1, inputs encoding 5-7 -> regValRnOut=0xFFFF_FFFF_FFFF_FFFD, tOut=1, tWrOut=1.
REQ-024 CMPGT with Rm=-1, Ri=1 (rmSign=1, riSign=0) -> tOut=0, validOut=0, tWrOut=1; CMPHI with the same operands -> tOut=1.
REQ-025 ADDX low half 0xFFFF_FFFF_FFFF_FFFF+1, then high half 0+0 -> outputs 0, then 1; tOut=0 then tWrOut=1 on the second cycle; xHiOut=1 between the two.
REQ-026 holdIn=1 for 3 cycles during HI -> outputs and xHiOut frozen; then flushIn=1 -> validOut=0, xHiOut=0.
REQ-027 reset pulsed low mid-ADDX -> all outputs 0 immediately (asynchronously); a following op E executes as a low half.

Source files
------------

// File: rtl/jx2_ex_alu_resolve_if.sv
// jx2_ex_alu_resolve_if: request/result bundle for the EX-stage ALU resolve
// block. The adder stage (master) drives the carry-select half-sums and the
// packed results; the resolve block (slave) returns the registered result.
interface jx2_ex_alu_resolve_if;
  logic        validIn;
  logic        holdIn;
  logic        flushIn;
  logic [3:0]  opIn;
  logic        tIn;
  logic [6:0]  regIdRnIn;
  logic        rmSign;
  logic        riSign;
  logic [32:0] addRmRi_A0;
  logic [32:0] addRmRi_A1;
  logic [32:0] addRmRi_B0;
  logic [32:0] addRmRi_B1;
  logic [32:0] subRmRi_A0;
  logic [32:0] subRmRi_A1;
  logic [32:0] subRmRi_B0;
  logic [32:0] subRmRi_B1;
  logic [63:0] aluPAddW;
  logic [63:0] aluPAddL;
  logic [63:0] aluPSubW;
  logic [63:0] aluPSubL;
  logic        validOut;
  logic [6:0]  regIdRnOut;
  logic [63:0] regValRnOut;
  logic        tOut;
  logic        tWrOut;
  logic        xHiOut;

  modport master (
    output validIn, holdIn, flushIn, opIn, tIn, regIdRnIn, rmSign, riSign,
    output addRmRi_A0, addRmRi_A1, addRmRi_B0, addRmRi_B1,
    output subRmRi_A0, subRmRi_A1, subRmRi_B0, subRmRi_B1,
    output aluPAddW, aluPAddL, aluPSubW, aluPSubL,
    input  validOut, regIdRnOut, regValRnOut, tOut, tWrOut, xHiOut
  );

  modport slave (
    input  validIn, holdIn, flushIn, opIn, tIn, regIdRnIn, rmSign, riSign,
    input  addRmRi_A0, addRmRi_A1, addRmRi_B0, addRmRi_B1,
    input  subRmRi_A0, subRmRi_A1, subRmRi_B0, subRmRi_B1,
    input  aluPAddW, aluPAddL, aluPSubW, aluPSubL,
    output validOut, regIdRnOut, regValRnOut, tOut, tWrOut, xHiOut
  );
endinterface

// File: rtl/jx2_ex_alu_resolve.sv
// jx2_ex_alu_resolve: final EX-stage ALU step. Resolves the carry-select
// half-sums into a 64-bit add/sub result, evaluates compares into SR.T and
// registers the writeback (one cycle latency).
// Optional feature macro JX2_ALU_ADDX_EN: enables ADDX/SUBX (ops E/F), a
// two-step 128-bit add/sub carried through an IDLE/HI state machine. When the
// macro is undefined, ops E/F are NOPs and xHiOut is constant 0.
module jx2_ex_alu_resolve (
  input  logic                 clock,
  input  logic                 reset,
  jx2_ex_alu_resolve_if.slave  bus
);

  localparam int DATA_W = 64;
  localparam int HALF_W = 32;

  // Resolve one carry-select chain: {carry-out, 64-bit result}
  function automatic logic [DATA_W:0] carryChain(
    input logic [HALF_W:0] lo0,
    input logic [HALF_W:0] lo1,
    input logic [HALF_W:0] hi0,
    input logic [HALF_W:0] hi1,
    input logic            cIn
  );
    logic [HALF_W:0] lo;
    logic [HALF_W:0] hi;
    lo = cIn ? lo1 : lo0;
    hi = lo[HALF_W] ? hi1 : hi0;
    return {hi[HALF_W], hi[HALF_W-1:0], lo[HALF_W-1:0]};
  endfunction

  // Sign-extend the low word of a result to full width
  function automatic logic signed [DATA_W-1:0] signExtLow(
    input logic [DATA_W-1:0] v
  );
    logic signed [HALF_W-1:0] lo;
    lo = v[HALF_W-1:0];
    return DATA_W'(lo);
  endfunction

  logic              cIn;
  logic [DATA_W:0]   addRes;
  logic [DATA_W:0]   subRes;
  logic [DATA_W-1:0] addSum;
  logic [DATA_W-1:0] subSum;
  logic              addCo;
  logic              subCo;
  logic              ovf;

  logic              validNx;
  logic              tWrNx;
  logic              tNx;
  logic [6:0]        regIdNx;
  logic [DATA_W-1:0] regValNx;

  logic              validP1;
  logic              tWrP1;
  logic              tP1;
  logic [6:0]        regIdP1;
  logic [DATA_W-1:0] regValP1;

`ifdef JX2_ALU_ADDX_EN
  typedef enum logic {IDLE, HI} xState_t;
  xState_t state;
  xState_t stateNx;
  logic    xCarry;
  logic    xCarryNx;
  logic    hiPhase;

  assign hiPhase = (state == HI);
`endif

  // Carry-in selection per opcode
  always_comb begin
    cIn = 1'b0;
    case (bus.opIn)
      4'h2, 4'h5, 4'h6, 4'h7, 4'h9: cIn = 1'b1;
      4'h3:                         cIn = bus.tIn;
      4'h4:                         cIn = ~bus.tIn;
`ifdef JX2_ALU_ADDX_EN
      4'hE:                         cIn = hiPhase ? xCarry : 1'b0;
      4'hF:                         cIn = hiPhase ? xCarry : 1'b1;
`endif
      default:                      cIn = 1'b0;
    endcase
  end

  assign addRes = carryChain(bus.addRmRi_A0, bus.addRmRi_A1,
                             bus.addRmRi_B0, bus.addRmRi_B1, cIn);
  assign subRes = carryChain(bus.subRmRi_A0, bus.subRmRi_A1,
                             bus.subRmRi_B0, bus.subRmRi_B1, cIn);
  assign addSum = addRes[DATA_W-1:0];
  assign addCo  = addRes[DATA_W];
  assign subSum = subRes[DATA_W-1:0];
  assign subCo  = subRes[DATA_W];
  // Signed overflow of Rm - Ri: operand signs differ and result sign left Rm's
  assign ovf    = (bus.rmSign ^ bus.riSign) & (bus.rmSign ^ subSum[DATA_W-1]);

  // Opcode decode, flush handling and next-state selection
  always_comb begin
    validNx  = 1'b0;
    tWrNx    = 1'b0;
    tNx      = tP1;
    regIdNx  = regIdP1;
    regValNx = regValP1;
`ifdef JX2_ALU_ADDX_EN
    stateNx  = state;
    xCarryNx = xCarry;
`endif
    if (bus.flushIn) begin
`ifdef JX2_ALU_ADDX_EN
      stateNx = IDLE;
`endif
    end else if (bus.validIn) begin
`ifdef JX2_ALU_ADDX_EN
      // Any accepted op ends a pending high phase unless it is E/F below
      stateNx = IDLE;
`endif
      case (bus.opIn)
        4'h1: begin validNx = 1'b1; regIdNx = bus.regIdRnIn; regValNx = addSum; end
        4'h2: begin validNx = 1'b1; regIdNx = bus.regIdRnIn; regValNx = subSum; end
        4'h3: begin
          validNx = 1'b1; regIdNx = bus.regIdRnIn; regValNx = addSum;
          tNx = addCo; tWrNx = 1'b1;
        end
        4'h4: begin
          validNx = 1'b1; regIdNx = bus.regIdRnIn; regValNx = subSum;
          tNx = ~subCo; tWrNx = 1'b1;
        end
        4'h5: begin tNx = (subSum == '0); tWrNx = 1'b1; end
        4'h6: begin tNx = (subSum != '0) & (subSum[DATA_W-1] == ovf); tWrNx = 1'b1; end
        4'h7: begin tNx = subCo & (subSum != '0); tWrNx = 1'b1; end
        4'h8: begin validNx = 1'b1; regIdNx = bus.regIdRnIn; regValNx = signExtLow(addSum); end
        4'h9: begin validNx = 1'b1; regIdNx = bus.regIdRnIn; regValNx = signExtLow(subSum); end
        4'hA: begin validNx = 1'b1; regIdNx = bus.regIdRnIn; regValNx = bus.aluPAddW; end
        4'hB: begin validNx = 1'b1; regIdNx = bus.regIdRnIn; regValNx = bus.aluPAddL; end
        4'hC: begin validNx = 1'b1; regIdNx = bus.regIdRnIn; regValNx = bus.aluPSubW; end
        4'hD: begin validNx = 1'b1; regIdNx = bus.regIdRnIn; regValNx = bus.aluPSubL; end
`ifdef JX2_ALU_ADDX_EN
        4'hE: begin
          validNx = 1'b1; regIdNx = bus.regIdRnIn; regValNx = addSum;
          if (hiPhase) begin
            tNx = addCo; tWrNx = 1'b1;
          end else begin
            xCarryNx = addCo; stateNx = HI;
          end
        end
        4'hF: begin
          validNx = 1'b1; regIdNx = bus.regIdRnIn; regValNx = subSum;
          if (hiPhase) begin
            tNx = ~subCo; tWrNx = 1'b1;
          end else begin
            xCarryNx = subCo; stateNx = HI;
          end
        end
`endif
        default: ;
      endcase
    end
  end

  // Output register stage; holdIn freezes everything
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      validP1  <= 1'b0;
      tWrP1    <= 1'b0;
      tP1      <= 1'b0;
      regIdP1  <= '0;
      regValP1 <= '0;
    end else if (!bus.holdIn) begin
      validP1  <= validNx;
      tWrP1    <= tWrNx;
      tP1      <= tNx;
      regIdP1  <= regIdNx;
      regValP1 <= regValNx;
    end
  end

`ifdef JX2_ALU_ADDX_EN
  // ADDX/SUBX phase register and carry between halves
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state  <= IDLE;
      xCarry <= 1'b0;
    end else if (!bus.holdIn) begin
      state  <= stateNx;
      xCarry <= xCarryNx;
    end
  end

  assign bus.xHiOut = hiPhase;
`else
  assign bus.xHiOut = 1'b0;
`endif

  assign bus.validOut    = validP1;
  assign bus.tWrOut      = tWrP1;
  assign bus.tOut        = tP1;
  assign bus.regIdRnOut  = regIdP1;
  assign bus.regValRnOut = regValP1;

endmodule
